// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down counter timer.
// The state encoding is fixed at 2 bits so it can be probed in waveforms and by downstream debug logic.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } dct_state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable synchronous down counter with a one-cycle terminal-count pulse.
// Supports one-shot and auto-reload (periodic) operation.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  dct_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // State, count, reload value and both status flags are all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  // Load always wins; otherwise an enabled RUN/PAUSE decrements, with the step from 1 being the terminal event.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      if (load_val != ZERO) begin
        state_d = en ? RUN : PAUSE;
      end else begin
        state_d = IDLE;
        tc_d    = 1'b1;
      end
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (!en) begin
            state_d = PAUSE;
          end else if (count_q > ONE) begin
            state_d = RUN;
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            tc_d = 1'b1;
            if (auto_reload) begin
              state_d = RUN;
              count_d = reload_q;
            end else begin
              state_d = DONE;
              count_d = ZERO;
            end
          end else begin
            // A zero count here is unreachable; park safely without wrapping.
            state_d = DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer at WIDTH=4.
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int checks;
  int errors;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outputs(input string name, input logic [WIDTH-1:0] exp_q,
                                input logic exp_tc, input logic exp_busy);
    checks++;
    if (q !== exp_q || tc !== exp_tc || busy !== exp_busy) begin
      errors++;
      $display("[TB] FAIL %s: got q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=%b",
               name, q, tc, busy, exp_q, exp_tc, exp_busy);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] value);
    load     = 1'b1;
    load_val = value;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    expect_outputs("reset_state", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    expect_outputs("idle_after_reset", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_one_shot();
    en          = 1'b1;
    auto_reload = 1'b0;
    do_load(4'd3);
    expect_outputs("oneshot_load", 4'd3, 1'b0, 1'b1);
    tick();
    expect_outputs("oneshot_q2", 4'd2, 1'b0, 1'b1);
    tick();
    expect_outputs("oneshot_q1", 4'd1, 1'b0, 1'b1);
    tick();
    expect_outputs("oneshot_terminal", 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_outputs($sformatf("oneshot_hold%0d", i), 4'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] exp_q;
    logic             exp_tc;
    en          = 1'b1;
    auto_reload = 1'b1;
    do_load(4'd4);
    expect_outputs("periodic_load", 4'd4, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_tc = ((i % 4) == 0);
      exp_q  = exp_tc ? 4'd4 : 4'(4 - (i % 4));
      expect_outputs($sformatf("periodic_edge%0d", i), exp_q, exp_tc, 1'b1);
    end
    auto_reload = 1'b0;
    tick();
    expect_outputs("periodic_stop_q3", 4'd3, 1'b0, 1'b1);
    tick();
    tick();
    expect_outputs("periodic_stop_q1", 4'd1, 1'b0, 1'b1);
    tick();
    expect_outputs("periodic_stop_done", 4'd0, 1'b1, 1'b0);
    tick();
    expect_outputs("periodic_done_hold", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_enable_gating();
    logic [4:0]       pattern;
    logic [WIDTH-1:0] exp_q;
    pattern     = 5'b10011;
    auto_reload = 1'b0;
    en          = 1'b1;
    do_load(4'd6);
    expect_outputs("gating_load", 4'd6, 1'b0, 1'b1);
    exp_q = 4'd6;
    for (int i = 0; i < 5; i++) begin
      en = pattern[i];
      tick();
      if (pattern[i]) exp_q = exp_q - 4'd1;
      expect_outputs($sformatf("gating_step%0d", i), exp_q, 1'b0, 1'b1);
    end
  endtask

  task automatic test_collision();
    en          = 1'b1;
    auto_reload = 1'b0;
    do_load(4'd2);
    tick();
    expect_outputs("collision_q1", 4'd1, 1'b0, 1'b1);
    do_load(4'd9);
    expect_outputs("collision_load_wins", 4'd9, 1'b0, 1'b1);
    tick();
    expect_outputs("collision_running", 4'd8, 1'b0, 1'b1);
  endtask

  task automatic test_boundary_max();
    en          = 1'b1;
    auto_reload = 1'b0;
    do_load(4'd15);
    expect_outputs("max_load", 4'd15, 1'b0, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      expect_outputs($sformatf("max_edge%0d", i), 4'(15 - i), 1'b0, 1'b1);
    end
    tick();
    expect_outputs("max_terminal", 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_load_zero();
    en = 1'b1;
    do_load(4'd0);
    expect_outputs("zero_load_tc", 4'd0, 1'b1, 1'b0);
    tick();
    expect_outputs("zero_load_idle", 4'd0, 1'b0, 1'b0);
    tick();
    expect_outputs("zero_load_hold", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset_mid_count();
    en          = 1'b1;
    auto_reload = 1'b0;
    do_load(4'd5);
    tick();
    tick();
    expect_outputs("async_pre_reset", 4'd3, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_outputs("async_reset_immediate", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outputs($sformatf("async_post_release%0d", i), 4'd0, 1'b0, 1'b0);
    end
    do_load(4'd2);
    expect_outputs("async_reload", 4'd2, 1'b0, 1'b1);
    tick();
    expect_outputs("async_recount", 4'd1, 1'b0, 1'b1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    load        = 1'b0;
    load_val    = '0;
    en          = 1'b0;
    auto_reload = 1'b0;

    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gating();
    test_collision();
    test_boundary_max();
    test_load_zero();
    test_async_reset_mid_count();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
